// File: rtl/pan_sweep_sched.sv
// Pan-servo position scheduler: idle / periodic scan / object follow / lost-object hold.
// Angle moves at most STEP per dwell tick; angle_vld flags every registered angle change.
module pan_sweep_sched #(
  parameter int ANG_W    = 8,
  parameter int ANG_MIN  = 10,
  parameter int ANG_MAX  = 170,
  parameter int ANG_HOME = 90,
  parameter int STEP     = 2,
  parameter int DWELL    = 500000,
  parameter int LOST_TO  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sweep_en,
  input  logic             stop,
  input  logic             obj_valid,
  input  logic [ANG_W-1:0] obj_angle,
  output logic [ANG_W-1:0] angle,
  output logic             angle_vld,
  output logic [1:0]       state,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_TRACK = 2'd2,
    S_LOST  = 2'd3
  } state_t;

  typedef logic [ANG_W:0] wide_t;

  localparam int CNT_W  = $clog2(DWELL);
  localparam int LOST_W = $clog2(LOST_TO + 1);

  localparam wide_t MIN_W  = wide_t'(ANG_MIN);
  localparam wide_t MAX_W  = wide_t'(ANG_MAX);
  localparam wide_t STEP_W = wide_t'(STEP);
  localparam logic [ANG_W-1:0] HOME = ANG_W'(ANG_HOME);

  state_t            state_q, state_d;
  logic [ANG_W-1:0]  angle_q, angle_d;
  logic              dir_q, dir_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LOST_W-1:0] lost_q, lost_d, lost_inc;
  logic              vld_q, vld_d;
  logic              busy_q, busy_d;
  logic              tick;

  // One scan step; returns {dir, angle}. Ends clamp and reverse direction.
  function automatic logic [ANG_W:0] sweep_step(input logic dir, input logic [ANG_W-1:0] a);
    wide_t cur;
    wide_t nxt;
    cur = {1'b0, a};
    if (dir) begin
      nxt = cur + STEP_W;
      if (nxt >= MAX_W) return {1'b0, MAX_W[ANG_W-1:0]};
      return {1'b1, nxt[ANG_W-1:0]};
    end
    if (cur < MIN_W + STEP_W) return {1'b1, MIN_W[ANG_W-1:0]};
    nxt = cur - STEP_W;
    return {1'b0, nxt[ANG_W-1:0]};
  endfunction

  function automatic wide_t clamp_target(input logic [ANG_W-1:0] a);
    wide_t w;
    w = {1'b0, a};
    if (w < MIN_W) return MIN_W;
    if (w > MAX_W) return MAX_W;
    return w;
  endfunction

  // Move toward the clamped target, snapping when within one step.
  function automatic logic [ANG_W-1:0] track_step(input logic [ANG_W-1:0] a,
                                                  input logic [ANG_W-1:0] tgt);
    wide_t cur;
    wide_t t;
    wide_t r;
    cur = {1'b0, a};
    t   = clamp_target(tgt);
    if (t > cur) r = (t - cur <= STEP_W) ? t : cur + STEP_W;
    else         r = (cur - t <= STEP_W) ? t : cur - STEP_W;
    return r[ANG_W-1:0];
  endfunction

  assign tick     = (state_q != S_IDLE) && (cnt_q == CNT_W'(DWELL - 1));
  assign lost_inc = lost_q + LOST_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      angle_q <= HOME;
      dir_q   <= 1'b1;
      cnt_q   <= '0;
      lost_q  <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      angle_q <= angle_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      lost_q  <= lost_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    angle_d = angle_q;
    dir_d   = dir_q;
    lost_d  = lost_q;
    if (stop && state_q != S_IDLE) begin
      state_d = S_IDLE;
      angle_d = HOME;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          angle_d = HOME;
          if (sweep_en) begin
            state_d = S_SWEEP;
            dir_d   = 1'b1;
          end
        end
        S_SWEEP: begin
          if (obj_valid)  state_d = S_TRACK;
          else if (tick) {dir_d, angle_d} = sweep_step(dir_q, angle_q);
        end
        S_TRACK: begin
          if (tick) begin
            if (obj_valid) begin
              angle_d = track_step(angle_q, obj_angle);
            end else begin
              state_d = S_LOST;
              lost_d  = '0;
            end
          end
        end
        S_LOST: begin
          if (obj_valid) begin
            state_d = S_TRACK;
          end else if (tick) begin
            lost_d = lost_inc;
            if (lost_inc == LOST_W'(LOST_TO)) state_d = S_SWEEP;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    // Dwell restarts on every state change so the first tick lands DWELL cycles after entry.
    if (state_d != state_q || state_q == S_IDLE || tick) cnt_d = '0;
    else                                                cnt_d = cnt_q + CNT_W'(1);
  end

  always_comb begin
    vld_d  = (angle_d != angle_q);
    busy_d = (state_d != S_IDLE);
  end

  assign angle     = angle_q;
  assign angle_vld = vld_q;
  assign state     = state_q;
  assign busy      = busy_q;

endmodule
